// File: rtl/xmos_slice_io_ctrl.sv
// xmos_slice_io_ctrl: serially loaded pin direction/value shadows with atomic commit and pin readback
module xmos_slice_io_ctrl #(
    parameter int NPIN        = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic            sclk,
    input  logic            ssel_n,
    input  logic            mosi,
    output logic            miso,
    input  logic [NPIN-1:0] pin_in,
    output logic [NPIN-1:0] pin_oe,
    output logic [NPIN-1:0] pin_out,
    output logic            busy,
    output logic            err
);
    localparam int CW = $clog2(NPIN + 2);

    typedef enum logic [2:0] {IDLE, CMD, DATA, READ, SKIP} state_t;

    state_t                 state, state_nx;
    logic [SYNC_STAGES-1:0] sclk_s, ssel_s, mosi_s;
    logic                   sclk_d, rise, fall, ssel_hi, cmd_done, wr_out;
    logic [CW-1:0]          cnt;
    logic [NPIN-1:0]        sr, sr_nx, read_sr, dir_sh, out_sh;
    logic [7:0]             cmd;

    assign ssel_hi = ssel_s[SYNC_STAGES-1];
    assign rise    = sclk_s[SYNC_STAGES-1] & ~sclk_d;
    assign fall    = ~sclk_s[SYNC_STAGES-1] & sclk_d;
    assign sr_nx   = {sr[NPIN-2:0], mosi_s[SYNC_STAGES-1]};
    assign cmd     = sr[7:0];

    // ssel_n synchronizer resets high so a reset never looks like a frame start
    always_ff @(posedge CLK or negedge nRST)
        if (!nRST) begin
            sclk_s <= '0;
            ssel_s <= '1;
            mosi_s <= '0;
            sclk_d <= 1'b0;
        end else begin
            sclk_s <= {sclk_s[SYNC_STAGES-2:0], sclk};
            ssel_s <= {ssel_s[SYNC_STAGES-2:0], ssel_n};
            mosi_s <= {mosi_s[SYNC_STAGES-2:0], mosi};
            sclk_d <= sclk_s[SYNC_STAGES-1];
        end

    always_ff @(posedge CLK or negedge nRST)
        if (!nRST) state <= IDLE;
        else       state <= state_nx;

    always_comb begin
        state_nx = state;
        if (ssel_hi) state_nx = IDLE;
        else
            case (state)
                IDLE:    state_nx = CMD;
                CMD:     if (cmd_done) state_nx = (cmd == 8'h01 || cmd == 8'h02) ? DATA :
                                                  (cmd == 8'h04) ? READ : SKIP;
                DATA:    if (rise && cnt == CW'(NPIN - 1)) state_nx = SKIP;
                READ:    if (fall && cnt == CW'(NPIN)) state_nx = SKIP;
                default: ;
            endcase
    end

    // the command is decoded one cycle after its 8th bit lands in sr
    always_ff @(posedge CLK or negedge nRST)
        if (!nRST) begin
            cnt      <= '0;
            cmd_done <= 1'b0;
            wr_out   <= 1'b0;
            sr       <= '0;
            read_sr  <= '0;
            dir_sh   <= '0;
            out_sh   <= '0;
            pin_oe   <= '0;
            pin_out  <= '0;
            miso     <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
        end else begin
            busy <= ~ssel_hi;
            if (state != READ) miso <= 1'b0;
            if (ssel_hi || state == IDLE) begin
                cnt      <= '0;
                cmd_done <= 1'b0;
            end else if (state == CMD && cmd_done) begin
                cnt      <= '0;
                cmd_done <= 1'b0;
                wr_out   <= cmd == 8'h02;
                if (cmd == 8'h03) begin
                    pin_oe  <= dir_sh;
                    pin_out <= out_sh;
                end
                if (cmd == 8'h04) read_sr <= pin_in;
                if (cmd == 8'h05) err <= 1'b0;
                else if (cmd == 8'h00 || cmd > 8'h05) err <= 1'b1;
            end else if (state == CMD && rise) begin
                sr       <= sr_nx;
                cnt      <= cnt + 1'b1;
                cmd_done <= cnt == CW'(7);
            end else if (state == DATA && rise) begin
                sr  <= sr_nx;
                cnt <= cnt + 1'b1;
                if (cnt == CW'(NPIN - 1)) begin
                    if (wr_out) out_sh <= sr_nx;
                    else        dir_sh <= sr_nx;
                end
            end else if (state == READ && fall) begin
                miso    <= (cnt == CW'(NPIN)) ? 1'b0 : read_sr[NPIN-1];
                read_sr <= read_sr << 1;
                cnt     <= cnt + 1'b1;
            end
        end
endmodule

// File: tb/tb_xmos_slice_io_ctrl.sv
// tb_xmos_slice_io_ctrl: frame table with scoreboard plus latency, abort and reset corner sequences
module tb_xmos_slice_io_ctrl;
    logic        clk = 1'b0, nrst = 1'b0, sclk = 1'b0, ssel_n = 1'b1, mosi = 1'b0;
    logic        miso, busy, err;
    logic [15:0] pin_in = '0, pin_oe, pin_out;
    int          errors = 0, checks = 0;

    always #5 clk = ~clk;

    xmos_slice_io_ctrl #(.NPIN(16), .SYNC_STAGES(2)) dut (
        .CLK(clk), .nRST(nrst), .sclk(sclk), .ssel_n(ssel_n), .mosi(mosi), .miso(miso),
        .pin_in(pin_in), .pin_oe(pin_oe), .pin_out(pin_out), .busy(busy), .err(err)
    );

    typedef struct {
        logic [7:0]  cmd;
        logic [15:0] data;
        int          nd;
        logic [15:0] pin;
        logic [15:0] oe, out;
        logic        er, rc;
    } vec_t;

    typedef struct {
        logic [15:0] oe, out, rd;
        logic        er, rc;
    } exp_t;

    vec_t vt[14];
    exp_t sb[$];

    function automatic vec_t mk(input logic [7:0] c, input logic [15:0] d, input int n,
                                input logic [15:0] p, input logic [15:0] oe, input logic [15:0] out,
                                input logic er, input logic rc);
        vec_t v;
        v.cmd = c; v.data = d; v.nd = n; v.pin = p; v.oe = oe; v.out = out; v.er = er; v.rc = rc;
        return v;
    endfunction

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    task automatic xbit(input logic b, output logic so);
        mosi = b;
        repeat (4) @(negedge clk);
        so   = miso;
        sclk = 1'b1;
        repeat (4) @(negedge clk);
        sclk = 1'b0;
    endtask

    task automatic start_frame();
        ssel_n = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic end_frame();
        repeat (4) @(negedge clk);
        ssel_n = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    // for RD_PIN, pin_in is cleared mid-read to prove the snapshot holds
    task automatic send_frame(input vec_t v, output logic [15:0] rd);
        logic so;
        rd = '0;
        pin_in = v.pin;
        start_frame();
        for (int i = 0; i < 8; i++) xbit(v.cmd[7-i], so);
        chk("busy_mid", {31'd0, busy}, 32'd1);
        for (int i = 0; i < v.nd; i++) begin
            if (v.cmd == 8'h04 && i == 4) pin_in = '0;
            xbit(v.data[15-i], so);
            rd = {rd[14:0], so};
        end
        end_frame();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [15:0] rd;
        logic [7:0]  c;
        logic        so;
        exp_t        e;
        vt[0]  = mk(8'h01, 16'h00FF, 16, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
        vt[1]  = mk(8'h02, 16'h0055, 16, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
        vt[2]  = mk(8'h03, 16'h0000,  0, 16'h0000, 16'h00FF, 16'h0055, 1'b0, 1'b0);
        vt[3]  = mk(8'h01, 16'hFFFF, 16, 16'h0000, 16'h00FF, 16'h0055, 1'b0, 1'b0);
        vt[4]  = mk(8'h03, 16'h0000,  0, 16'h0000, 16'hFFFF, 16'h0055, 1'b0, 1'b0);
        vt[5]  = mk(8'h02, 16'h1234, 10, 16'h0000, 16'hFFFF, 16'h0055, 1'b0, 1'b0);
        vt[6]  = mk(8'h03, 16'h0000,  0, 16'h0000, 16'hFFFF, 16'h0055, 1'b0, 1'b0);
        vt[7]  = mk(8'h04, 16'h0000, 16, 16'hA5C3, 16'hFFFF, 16'h0055, 1'b0, 1'b1);
        vt[8]  = mk(8'h7E, 16'h0000,  0, 16'h0000, 16'hFFFF, 16'h0055, 1'b1, 1'b0);
        vt[9]  = mk(8'h01, 16'h0F0F, 16, 16'h0000, 16'hFFFF, 16'h0055, 1'b1, 1'b0);
        vt[10] = mk(8'h03, 16'h0000,  0, 16'h0000, 16'h0F0F, 16'h0055, 1'b1, 1'b0);
        vt[11] = mk(8'h05, 16'h0000,  0, 16'h0000, 16'h0F0F, 16'h0055, 1'b0, 1'b0);
        vt[12] = mk(8'h00, 16'h0000,  0, 16'h0000, 16'h0F0F, 16'h0055, 1'b1, 1'b0);
        vt[13] = mk(8'h05, 16'h0000,  0, 16'h0000, 16'h0F0F, 16'h0055, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        chk("rst_oe", {16'd0, pin_oe}, 32'd0);
        chk("rst_out", {16'd0, pin_out}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_miso", {31'd0, miso}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        nrst = 1'b1;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            e.oe = vt[i].oe; e.out = vt[i].out; e.er = vt[i].er; e.rc = vt[i].rc; e.rd = vt[i].pin;
            sb.push_back(e);
            send_frame(vt[i], rd);
            e = sb.pop_front();
            chk($sformatf("v%0d_oe", i), {16'd0, pin_oe}, {16'd0, e.oe});
            chk($sformatf("v%0d_out", i), {16'd0, pin_out}, {16'd0, e.out});
            chk($sformatf("v%0d_err", i), {31'd0, err}, {31'd0, e.er});
            chk($sformatf("v%0d_miso", i), {31'd0, miso}, 32'd0);
            chk($sformatf("v%0d_busy", i), {31'd0, busy}, 32'd0);
            if (e.rc) chk($sformatf("v%0d_rd", i), {16'd0, rd}, {16'd0, e.rd});
        end

        // commit latency: pins move on the 4th CLK after the raw 8th sclk rise
        send_frame(mk(8'h01, 16'h3C3C, 16, 16'h0000, 16'h0, 16'h0, 1'b0, 1'b0), rd);
        c = 8'h03;
        start_frame();
        for (int i = 0; i < 7; i++) xbit(c[7-i], so);
        mosi = c[0];
        repeat (4) @(negedge clk);
        sclk = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("lat_oe_before", {16'd0, pin_oe}, 32'h0F0F);
        @(posedge clk);
        #1;
        chk("lat_oe_after", {16'd0, pin_oe}, 32'h3C3C);
        chk("lat_out_after", {16'd0, pin_out}, 32'h0055);
        repeat (4) @(negedge clk);
        sclk = 1'b0;
        end_frame();

        // reset in the middle of a DATA frame, with err set beforehand
        send_frame(mk(8'hC3, 16'h0000, 0, 16'h0000, 16'h0, 16'h0, 1'b0, 1'b0), rd);
        chk("pre_rst_err", {31'd0, err}, 32'd1);
        c = 8'h01;
        start_frame();
        for (int i = 0; i < 8; i++) xbit(c[7-i], so);
        for (int i = 0; i < 5; i++) xbit(1'b1, so);
        @(negedge clk);
        nrst = 1'b0;
        #1;
        chk("mid_rst_oe", {16'd0, pin_oe}, 32'd0);
        chk("mid_rst_out", {16'd0, pin_out}, 32'd0);
        chk("mid_rst_err", {31'd0, err}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_miso", {31'd0, miso}, 32'd0);
        ssel_n = 1'b1;
        mosi = 1'b0;
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        repeat (3) @(negedge clk);
        send_frame(mk(8'h03, 16'h0000, 0, 16'h0000, 16'h0, 16'h0, 1'b0, 1'b0), rd);
        chk("post_rst_commit_oe", {16'd0, pin_oe}, 32'd0);
        chk("post_rst_commit_out", {16'd0, pin_out}, 32'd0);
        send_frame(mk(8'h02, 16'h00F0, 16, 16'h0000, 16'h0, 16'h0, 1'b0, 1'b0), rd);
        send_frame(mk(8'h03, 16'h0000, 0, 16'h0000, 16'h0, 16'h0, 1'b0, 1'b0), rd);
        chk("post_rst_out", {16'd0, pin_out}, 32'h00F0);
        chk("post_rst_oe", {16'd0, pin_oe}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
